// File: rtl/iccm_boot_arbiter.sv
`default_nettype none
// ============================================================================
// iccm_boot_arbiter : ICCM SRAM port owner and boot sequencer (loader -> core)
// Optional feature macro: ICCM_ARB_BOOT_TIMEOUT_EN (boot without a load)
// Revision: 1.0
// ============================================================================
module iccm_boot_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int RELEASE_DLY  = 4,
    parameter int BOOT_TIMEOUT = 1000000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ldr_we_i,
    input  logic [ADDR_W-1:0]   ldr_addr_i,
    input  logic [DATA_W-1:0]   ldr_wdata_i,
    input  logic                ldr_done_i,
    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                core_rst_no,
    output logic [1:0]          boot_state_o,
    output logic [ADDR_W:0]     wr_count_o,
    output logic                drop_o,
    output logic                timeout_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_HANDOFF = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               drop_q, drop_d;
    logic               rvalid_q, rvalid_d;
    logic               core_rst_q;
    logic               ldr_own;
    logic               ldr_wr;
    logic               core_gnt;
    logic               tmo_hit;

`ifdef ICCM_ARB_BOOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(BOOT_TIMEOUT + 1);

    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               timeout_q, timeout_d;

    // Counts only uninterrupted quiet cycles in IDLE; anything else clears it.
    always_comb begin
        tmo_d     = '0;
        tmo_hit   = 1'b0;
        timeout_d = timeout_q;
        if (state_q == ST_IDLE && !ldr_we_i && !ldr_done_i) begin
            if (tmo_q == TMO_W'(BOOT_TIMEOUT - 1)) begin
                tmo_hit   = 1'b1;
                timeout_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign ldr_own  = (state_q != ST_RUN);
    assign ldr_wr   = ldr_own & ldr_we_i;
    assign core_gnt = core_req_i & (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ldr_done_i) begin
                    state_d = ST_HANDOFF;
                end else if (ldr_we_i) begin
                    state_d = ST_LOAD;
                end else if (tmo_hit) begin
                    state_d = ST_HANDOFF;
                end
            end
            ST_LOAD: begin
                if (ldr_done_i) begin
                    state_d = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                if (dly_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // HANDOFF lasts exactly RELEASE_DLY cycles, counting down to zero.
        if (state_d == ST_HANDOFF && state_q != ST_HANDOFF) begin
            dly_d = DLY_W'(RELEASE_DLY - 1);
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (ldr_wr && !(&wr_cnt_q)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        drop_d   = drop_q | ((state_q == ST_RUN) & ldr_we_i);
        rvalid_d = core_gnt & ~core_we_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            wr_cnt_q   <= '0;
            drop_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_q     <= drop_d;
            rvalid_q   <= rvalid_d;
            core_rst_q <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        if (ldr_own) begin
            mem_req_o   = ldr_we_i;
            mem_we_o    = ldr_we_i;
            mem_be_o    = {BE_W{1'b1}};
            mem_addr_o  = ldr_addr_i;
            mem_wdata_o = ldr_wdata_i;
        end else begin
            mem_req_o   = core_req_i;
            mem_we_o    = core_we_i;
            mem_be_o    = core_be_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = mem_rdata_i;
    assign core_rst_no   = core_rst_q;
    assign boot_state_o  = state_q;
    assign wr_count_o    = wr_cnt_q;
    assign drop_o        = drop_q;

endmodule
`default_nettype wire

// File: doc/iccm_boot_arbiter.md
# iccm_boot_arbiter

Owns the single ICCM SRAM port and sequences boot. After reset it grants the port to the UART boot loader (write-only, one word per pulse) and holds the core in reset. When the loader signals completion, it waits a fixed drain delay, hands the port to the core's instruction/data interface and releases core reset. It sits between the UART loader, the core's ICCM request interface and the ICCM SRAM macro.

## Interface
- ADDR_W, 14, ICCM word-address width
- DATA_W, 32, ICCM word width
- RELEASE_DLY, 4, cycles spent in HANDOFF before the core owns the port (>=1)
- BOOT_TIMEOUT, 1000000, idle cycles before booting without a load (used only with the timeout macro)

- clk_i  in  1  clock; the block has one clock
- rst_ni  in  1  reset, asynchronous, active-low
- ldr_we_i  in  1  loader write pulse
- ldr_addr_i  in  ADDR_W  loader word address
- ldr_wdata_i  in  DATA_W  loader write data
- ldr_done_i  in  1  loader finished; level, stays high once set
- core_req_i  in  1  core access request
- core_we_i  in  1  core write enable
- core_be_i  in  DATA_W/8  core byte enables
- core_addr_i  in  ADDR_W  core word address
- core_wdata_i  in  DATA_W  core write data
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  read data valid
- core_rdata_o  out  DATA_W  read data, pass-through of mem_rdata_i
- mem_req_o, mem_we_o  out  1 each  SRAM request / write
- mem_be_o  out  DATA_W/8  SRAM byte enables
- mem_addr_o  out  ADDR_W  SRAM address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_rdata_i  in  DATA_W  SRAM read data, one cycle after the read request
- core_rst_no  out  1  core reset, active-low, registered
- boot_state_o  out  2  IDLE=0, LOAD=1, HANDOFF=2, RUN=3
- wr_count_o  out  ADDR_W+1  loader writes accepted, saturating at all-ones
- drop_o  out  1  sticky: a loader write arrived in RUN
- timeout_o  out  1  sticky: boot was entered by timeout

## Operation
- IDLE: loader owns the port. ldr_we_i -> LOAD (the write is performed). ldr_done_i -> HANDOFF. If both are high, the write is performed and the next state is HANDOFF.
- LOAD: loader owns the port. ldr_done_i -> HANDOFF. A write in the same cycle is still performed.
- HANDOFF: loader still owns the port, so late writes are performed. A down-counter is loaded with RELEASE_DLY-1 on entry; at 0 -> RUN.
- RUN: terminal until rst_ni. Core owns the port. ldr_we_i is ignored and sets drop_o.
- Port mux (combinational):
  - Loader-owned states: mem_req_o=mem_we_o=ldr_we_i, mem_be_o=all ones, addr/wdata from the loader.
  - RUN: mem_* follow core_*, mem_req_o=core_req_i.
- core_gnt_o = core_req_i & (state==RUN). The core is never granted in any other state.
- core_rvalid_o is registered: high the cycle after a granted read (core_we_i=0). Writes produce no rvalid.
- wr_count_o increments on every ldr_we_i performed (IDLE/LOAD/HANDOFF) and saturates.
- core_rst_no <= (next_state==RUN). It rises on the same edge that boot_state_o becomes 3.

## Timing
- Reset values: state IDLE, core_rst_no=0, core_gnt_o=0 (combinational), core_rvalid_o=0, mem_req_o=0, wr_count_o=0, drop_o=0, timeout_o=0.
- Asserting rst_ni low at any point, including mid-load or in RUN, immediately returns all of the above to reset values and drops core_rst_no asynchronously.
- Loader write: SRAM sees it in the same cycle as ldr_we_i (zero-cycle mux).
- Core read: gnt in cycle N, rvalid and rdata in N+1. Back-to-back grants every cycle are supported.
- ldr_done_i seen in cycle N (from LOAD): state is HANDOFF at N+1 and RUN at N+1+RELEASE_DLY; core_rst_no=1 from that edge.

## Configuration
- ICCM_ARB_BOOT_TIMEOUT_EN defined:
  - In IDLE only, a counter counts consecutive cycles with ldr_we_i=0 and ldr_done_i=0.
  - After BOOT_TIMEOUT such cycles the next state is HANDOFF and timeout_o sets.
  - Any loader activity clears the counter. The counter is inactive in LOAD.
- Not defined: no counter logic. IDLE waits indefinitely and timeout_o is tied to 0.

## Test plan
- Load 3 words (addr 0,1,2; data 0x00000093, 0x00100113, 0x00000fff), then ldr_done_i -> three SRAM writes with be=0xF, wr_count_o=3, RUN and core_rst_no=1 exactly 1+4 cycles after done.
- Core read at addr 1 in RUN -> gnt same cycle; rvalid next cycle with rdata=0x00100113. A core_req_i during LOAD -> gnt stays 0 and mem_req_o follows the loader only.
- ldr_we_i and ldr_done_i in the same cycle (addr 5, data 0xDEADBEEF) -> write performed, wr_count_o increments, HANDOFF next cycle. ldr_we_i in HANDOFF -> written. ldr_we_i in RUN -> no mem_req_o, drop_o=1.
- rst_ni low for 1 cycle while in RUN with a core read outstanding -> core_rst_no=0 immediately, rvalid=0, boot_state_o=0, counters cleared.
- With ICCM_ARB_BOOT_TIMEOUT_EN and BOOT_TIMEOUT=16, no loader activity -> HANDOFF after 16 idle cycles, timeout_o=1, RUN after 4 more. A ldr_we_i at idle cycle 10 -> LOAD, no timeout.
- Without the macro, 10000 idle cycles -> still IDLE, core_rst_no=0, timeout_o=0.
